// File: rtl/tree_accum_ctrl.sv
// tree_accum_ctrl: sequencing controller wrapped around a free-running adder tree.
//   Admits one product beat per cycle and gates the tree bias on the first
//   channel beat of each pixel. Each beat is followed through the tree latency
//   by a token. Per-channel tree sums are accumulated with saturation. On the
//   last channel the result is shifted, passed through optional ReLU, saturated
//   and placed in a single-entry valid/ready output register.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, cfg_*                layer start pulse and config (latched in IDLE)
//   busy, done                  layer status; done is a one-cycle pulse
//   in_valid/in_ready, bias_en  beat handshake from PE array, tree bias gate
//   tree_sum                    adder tree output, TREE_LATENCY after the beat
//   out_valid/out_ready/out_data  requantized result port
module tree_accum_ctrl #(
    parameter int TREE_WIDTH   = 20,
    parameter int ACC_WIDTH    = 24,
    parameter int OUT_WIDTH    = 8,
    parameter int TREE_LATENCY = 4,
    parameter int CH_W         = 10,
    parameter int PIX_W        = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [CH_W-1:0]              cfg_num_ch,
    input  logic [PIX_W-1:0]             cfg_num_pix,
    input  logic [4:0]                   cfg_shift,
    input  logic                         cfg_relu,
    output logic                         busy,
    output logic                         done,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         bias_en,
    input  logic signed [TREE_WIDTH-1:0] tree_sum,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OUT_WIDTH-1:0]  out_data
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    state_t state, state_nxt;

    logic [CH_W-1:0]              ch_last, ch_cnt;
    logic [PIX_W-1:0]             pix_last, pix_cnt;
    logic [4:0]                   shift_q;
    logic                         relu_q;
    logic [TREE_LATENCY-1:0]      vld_pipe, first_pipe, last_pipe;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic                         done_q;

    logic                         ch_is_last, lasts_in_flight, accept, tail_vld, tail_first, tail_last;
    logic signed [ACC_WIDTH-1:0]  tree_ext, acc_sat, acc_nxt, shifted, shifted_r;
    logic signed [ACC_WIDTH:0]    sum_wide;
    logic signed [OUT_WIDTH-1:0]  res;

    assign ch_is_last      = (ch_cnt == ch_last);
    assign lasts_in_flight = |(vld_pipe & last_pipe);
    assign tail_vld        = vld_pipe[TREE_LATENCY-1];
    assign tail_first      = first_pipe[TREE_LATENCY-1];
    assign tail_last       = last_pipe[TREE_LATENCY-1];

    // A last beat needs the output register to be free when its token
    // emerges: no other last in flight, and the held result (if any) leaving
    // this very cycle.
    assign in_ready = (state == RUN) &&
                      !(ch_is_last && (lasts_in_flight || (out_valid && !out_ready)));
    assign accept   = in_valid && in_ready;
    assign bias_en  = accept && (ch_cnt == '0);
    assign busy     = (state != IDLE);
    assign done     = done_q;

    // accumulate / requantize datapath for the token at the pipe tail
    always_comb begin
        tree_ext = {{(ACC_WIDTH-TREE_WIDTH){tree_sum[TREE_WIDTH-1]}}, tree_sum};
        sum_wide = {acc[ACC_WIDTH-1], acc} + {tree_ext[ACC_WIDTH-1], tree_ext};
        acc_sat  = sum_wide[ACC_WIDTH-1:0];
        if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1])
            acc_sat = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        acc_nxt   = tail_first ? tree_ext : acc_sat;
        shifted   = acc_nxt >>> shift_q;
        shifted_r = (relu_q && shifted < 0) ? '0 : shifted;
        if (shifted_r > OUT_MAX)
            res = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        else if (shifted_r < OUT_MIN)
            res = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        else
            res = shifted_r[OUT_WIDTH-1:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = (cfg_num_pix == '0) ? DONE : RUN;
            RUN:   if (accept && ch_is_last && pix_cnt == pix_last) state_nxt = DRAIN;
            DRAIN: if (!(|vld_pipe) && !out_valid) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            done_q     <= 1'b0;
            ch_last    <= '0;
            pix_last   <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            ch_cnt     <= '0;
            pix_cnt    <= '0;
            vld_pipe   <= '0;
            first_pipe <= '0;
            last_pipe  <= '0;
            acc        <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            state  <= state_nxt;
            done_q <= (state == DONE);

            if (state == IDLE && start) begin
                ch_last  <= (cfg_num_ch == '0) ? '0 : cfg_num_ch - CH_W'(1);
                pix_last <= cfg_num_pix - PIX_W'(1);
                shift_q  <= cfg_shift;
                relu_q   <= cfg_relu;
                ch_cnt   <= '0;
                pix_cnt  <= '0;
            end else if (accept) begin
                if (ch_is_last) begin
                    ch_cnt  <= '0;
                    pix_cnt <= pix_cnt + PIX_W'(1);
                end else begin
                    ch_cnt <= ch_cnt + CH_W'(1);
                end
            end

            vld_pipe   <= {vld_pipe[TREE_LATENCY-2:0], accept};
            first_pipe <= {first_pipe[TREE_LATENCY-2:0], accept && (ch_cnt == '0)};
            last_pipe  <= {last_pipe[TREE_LATENCY-2:0], accept && ch_is_last};

            if (tail_vld) acc <= acc_nxt;

            // a newly emerging result wins over the clear from a handoff
            if (tail_vld && tail_last) begin
                out_valid <= 1'b1;
                out_data  <= res;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
